// File: rtl/trace_feeder_if.sv
// Trace feeder bus bundle: trace BRAM read port plus the cache request/ack handshake.
// Ports: rom_en/rom_addr/rom_data (BRAM, data valid one cycle after rom_en),
//        trace_ready/mem_addr (request strobe + address), found_in_cache/updated_cache (acks).
interface trace_feeder_if #(
  parameter int ROM_AW = 10
);
  logic              rom_en;
  logic [ROM_AW-1:0] rom_addr;
  logic [31:0]       rom_data;
  logic              trace_ready;
  logic [31:0]       mem_addr;
  logic              found_in_cache;
  logic              updated_cache;

  // master = the feeder, slave = the BRAM/cache side
  modport master (
    output rom_en, rom_addr, trace_ready, mem_addr,
    input  rom_data, found_in_cache, updated_cache
  );

  modport slave (
    input  rom_en, rom_addr, trace_ready, mem_addr,
    output rom_data, found_in_cache, updated_cache
  );
endinterface

// File: rtl/trace_feeder.sv
// Purpose: walks a trace BRAM and issues each 32-bit address to the cache, one outstanding request.
// Latency: FETCH, WAIT_RD, ISSUE, then >=1 WAIT_ACK cycle, then GAP_CYCLES idle -> >=4 cycles/request.
// Backpressure: the next request waits for found_in_cache|updated_cache; TIMEOUT cycles without ack aborts.
// Ports: clk, rst (sync, active-high), start (pulse), bus (trace_feeder_if.master),
//        busy, done, timeout_err (sticky per run), issued_count (acked requests this run).
module trace_feeder #(
  parameter int NUM_TRACES = 1024,
  parameter int ROM_AW     = 10,
  parameter int GAP_CYCLES = 1,
  parameter int TIMEOUT    = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  trace_feeder_if.master        bus,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout_err,
  output logic [31:0]           issued_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_RD,
    S_ISSUE,
    S_WAIT_ACK,
    S_GAP,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ROM_AW-1:0] index_q;
  logic [31:0]       mem_addr_q;
  logic [31:0]       issued_q;
  logic              timeout_err_q;
  logic [31:0]       gap_q;
  logic [31:0]       tmo_q;

  logic ack;
  logic run_start;
  logic ack_take;
  logic tmo_fire;
  logic last_req;

  assign ack = bus.found_in_cache | bus.updated_cache;

  // Acks only count while waiting; a level held across other states is ignored.
  assign run_start = ((state_q == S_IDLE) || (state_q == S_DONE)) && start;
  assign ack_take  = (state_q == S_WAIT_ACK) && ack;
  // An ack arriving in the final allowed cycle wins over the timeout.
  assign tmo_fire  = (state_q == S_WAIT_ACK) && !ack && (tmo_q == 32'(TIMEOUT - 1));
  assign last_req  = (issued_q + 32'd1) == 32'(NUM_TRACES);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = (NUM_TRACES == 0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH:   state_d = S_WAIT_RD;
      S_WAIT_RD: state_d = S_ISSUE;
      S_ISSUE:   state_d = S_WAIT_ACK;
      S_WAIT_ACK: begin
        if (ack_take) begin
          if (last_req) begin
            state_d = S_DONE;
          end else if (GAP_CYCLES > 0) begin
            state_d = S_GAP;
          end else begin
            state_d = S_FETCH;
          end
        end else if (tmo_fire) begin
          state_d = S_DONE;
        end
      end
      S_GAP: begin
        if (gap_q == 32'(GAP_CYCLES - 1)) begin
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      index_q       <= '0;
      mem_addr_q    <= '0;
      issued_q      <= '0;
      timeout_err_q <= 1'b0;
      gap_q         <= '0;
      tmo_q         <= '0;
    end else begin
      if (run_start) begin
        index_q       <= '0;
        issued_q      <= '0;
        timeout_err_q <= 1'b0;
      end
      if (state_q == S_WAIT_RD) begin
        mem_addr_q <= bus.rom_data;
      end
      if (state_q == S_ISSUE) begin
        tmo_q <= '0;
      end else if (state_q == S_WAIT_ACK) begin
        tmo_q <= tmo_q + 32'd1;
      end
      if (ack_take) begin
        // index wraps naturally at the BRAM depth; issued_count wraps at 2^32
        issued_q <= issued_q + 32'd1;
        index_q  <= index_q + 1'b1;
        gap_q    <= '0;
      end
      if (tmo_fire) begin
        timeout_err_q <= 1'b1;
      end
      if (state_q == S_GAP) begin
        gap_q <= gap_q + 32'd1;
      end
    end
  end

  assign bus.rom_en      = (state_q == S_FETCH);
  assign bus.rom_addr    = index_q;
  assign bus.trace_ready = (state_q == S_ISSUE);
  assign bus.mem_addr    = mem_addr_q;
  assign busy            = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done            = (state_q == S_DONE);
  assign timeout_err     = timeout_err_q;
  assign issued_count    = issued_q;

endmodule

// File: tb/tb_trace_feeder.sv
// Bench for trace_feeder: random BRAM image, random/held/absent acks, timeout, mid-run reset,
// restart from DONE, start-while-busy, and a NUM_TRACES=0 instance.
`timescale 1ns/1ps
module tb_trace_feeder;
  localparam int N     = 12;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int GAP   = 2;
  localparam int TMO   = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, start0;
  logic        busy, done, terr;
  logic [31:0] icnt;
  logic        busy0, done0, terr0;
  logic [31:0] icnt0;

  trace_feeder_if #(.ROM_AW(AW)) tfi ();
  trace_feeder_if #(.ROM_AW(AW)) tfi0 ();

  trace_feeder #(.NUM_TRACES(N), .ROM_AW(AW), .GAP_CYCLES(GAP), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .bus(tfi),
    .busy(busy), .done(done), .timeout_err(terr), .issued_count(icnt)
  );

  trace_feeder #(.NUM_TRACES(0), .ROM_AW(AW), .GAP_CYCLES(0), .TIMEOUT(TMO)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .bus(tfi0),
    .busy(busy0), .done(done0), .timeout_err(terr0), .issued_count(icnt0)
  );

  assign tfi0.rom_data       = 32'h0;
  assign tfi0.found_in_cache = 1'b0;
  assign tfi0.updated_cache  = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Trace BRAM model: one-cycle read latency.
  logic [31:0] rom_img [DEPTH];
  always @(posedge clk) begin
    if (tfi.rom_en) tfi.rom_data <= rom_img[tfi.rom_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: request k of a run must carry rom_img[k mod DEPTH]; strobe spacing is
  // 3 + (WAIT_ACK cycles to ack) + GAP. ack_mode 0 = random delay, 1 = held high, 2 = never.
  int ack_mode   = 2;
  int d_left     = 0;
  int strobe_cnt = 0;
  int strobe_cyc = 0;
  int last_cyc   = 0;
  int per_exp    = 0;
  int zero_bad   = 0;

  always @(negedge clk) begin
    if (tfi0.rom_en || tfi0.trace_ready) zero_bad++;
    if (tfi.trace_ready) begin
      chk("mem_addr", tfi.mem_addr, rom_img[strobe_cnt % DEPTH]);
      if (strobe_cnt > 0 && per_exp > 0) chk("strobe_period", 32'(cyc - last_cyc), 32'(per_exp));
      last_cyc   = cyc;
      strobe_cyc = cyc;
      strobe_cnt++;
      tfi.found_in_cache = 1'b0;
      tfi.updated_cache  = 1'b0;
      if (ack_mode == 0) begin
        d_left  = $urandom_range(1, 4);
        per_exp = d_left + GAP + 3;
      end else if (ack_mode == 1) begin
        per_exp = 1 + GAP + 3;
      end else begin
        per_exp = 0;
      end
    end else if (ack_mode == 0 && d_left > 0) begin
      d_left--;
      if (d_left == 0) begin
        if ($urandom_range(0, 1) == 1) tfi.found_in_cache = 1'b1;
        else                           tfi.updated_cache  = 1'b1;
      end
    end
    if (ack_mode == 1) begin
      tfi.found_in_cache = 1'b1;
    end else if (ack_mode == 2) begin
      tfi.found_in_cache = 1'b0;
      tfi.updated_cache  = 1'b0;
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    strobe_cnt = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int waited);
    waited = 0;
    while (!done && waited < budget) begin
      @(negedge clk);
      waited++;
    end
    chk("done_within_budget", 32'(waited < budget), 32'd1);
  endtask

  task automatic run_once(input int mode, input bit poke);
    int waited;
    ack_mode = mode;
    d_left   = 0;
    pulse_start();
    chk("busy_after_start", busy, 1);
    chk("done_cleared", done, 0);
    chk("terr_cleared", terr, 0);
    chk("count_cleared", icnt, 0);
    waited = 0;
    while (!done && waited < 3000) begin
      start = (poke && waited == 10);
      @(negedge clk);
      waited++;
    end
    start = 1'b0;
    chk("run_done_within_budget", 32'(waited < 3000), 32'd1);
    chk("run_issued_count", icnt, N);
    chk("run_strobe_count", strobe_cnt, N);
    chk("run_busy_low", busy, 0);
    chk("run_no_timeout", terr, 0);
  endtask

  initial begin
    int waited;
    int done_cyc;
    for (int i = 0; i < DEPTH; i++) rom_img[i] = $urandom;
    rst = 1'b1; start = 1'b0; start0 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_trace_ready", tfi.trace_ready, 0);
    chk("rst_rom_en", tfi.rom_en, 0);
    chk("rst_rom_addr", tfi.rom_addr, 0);
    chk("rst_mem_addr", tfi.mem_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_terr", terr, 0);
    chk("rst_count", icnt, 0);

    // NUM_TRACES = 0: done on the very next cycle, no BRAM or cache activity
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    chk("zero_done", done0, 1);
    chk("zero_busy", busy0, 0);
    chk("zero_count", icnt0, 0);

    // random ack delays, index wraps past BRAM depth
    run_once(0, 1'b0);
    // ack held high throughout: one issue per request, ack never counted early
    run_once(1, 1'b0);
    // start pulsed mid-run is ignored
    run_once(0, 1'b1);

    // never ack: timeout after TMO WAIT_ACK cycles
    ack_mode = 2;
    pulse_start();
    wait_done(200, waited);
    done_cyc = cyc;
    chk("tmo_strobes", strobe_cnt, 1);
    chk("tmo_latency", 32'(done_cyc - strobe_cyc), 32'(TMO + 1));
    chk("tmo_err", terr, 1);
    chk("tmo_count", icnt, 0);
    chk("tmo_busy", busy, 0);

    // restart from DONE clears the sticky error
    run_once(0, 1'b0);

    // reset while waiting for the ack of request 2
    ack_mode = 0;
    d_left   = 0;
    pulse_start();
    waited = 0;
    while (strobe_cnt < 2 && waited < 500) begin
      @(negedge clk);
      #1;
      waited++;
    end
    chk("second_strobe_seen", strobe_cnt, 2);
    @(negedge clk);
    rst = 1'b1;
    ack_mode = 2;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_trace_ready", tfi.trace_ready, 0);
    chk("midrst_rom_en", tfi.rom_en, 0);
    chk("midrst_mem_addr", tfi.mem_addr, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_count", icnt, 0);
    repeat (5) @(negedge clk);
    chk("midrst_no_strobe", strobe_cnt, 2);
    run_once(0, 1'b0);

    chk("zero_inst_quiet", zero_bad, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
